// File: rtl/multicycle_controller.sv
// Moore sequencer for the multicycle MIPS datapath: steps each instruction through
// fetch/decode/execute/memory/writeback and drives all datapath selects and enables.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q, state_d;
  logic   pcwrite, branch;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d    = state_q;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    PCSrc      = 2'b00;
    illegal    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        IorD = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        state_d = S_ALUWB;
        case (funct)
          6'b100000: ALUControl = ALU_ADD;
          6'b100010: ALUControl = ALU_SUB;
          6'b100100: ALUControl = ALU_AND;
          6'b100101: ALUControl = ALU_OR;
          6'b101010: ALUControl = ALU_SLT;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    PCEn = pcwrite | (branch & zero);

    // The register is already FETCH during reset; squash FETCH's mem_ready-driven enables too.
    if (!rst_n) begin
      IRWrite  = 1'b0;
      PCEn     = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through its
// state sequence and compares state and the packed control vector against hand values.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Packed view of all control outputs, field order matching ctl() below.
  logic [15:0] ctl_vec;
  assign ctl_vec = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                    ALUSrcB, ALUControl, PCSrc, PCEn, illegal};

  function automatic logic [15:0] ctl(input logic iord, memw, irw, regdst, m2r, regw, srca,
                                      input logic [1:0] srcb, input logic [2:0] aluc,
                                      input logic [1:0] pcsrc, input logic pcen, ill);
    return {iord, memw, irw, regdst, m2r, regw, srca, srcb, aluc, pcsrc, pcen, ill};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Check the current cycle's state and controls, then advance to just after the next edge.
  task automatic step(input string tag, input logic [3:0] st, input logic [15:0] v);
    #1;
    check({tag, ".state"}, {12'd0, state}, {12'd0, st});
    check({tag, ".ctl"}, ctl_vec, v);
    @(posedge clk);
    #1;
  endtask

  logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] ac_tab [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

  initial begin
    rst_n = 1'b0; op = 6'b000000; funct = 6'b100000; zero = 1'b0; mem_ready = 1'b1;

    // Reset: FETCH selects, all enables low even though mem_ready=1
    #2;
    check("rst.state", {12'd0, state}, 16'd0);
    check("rst.ctl", ctl_vec, ctl(0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0));
    @(posedge clk); #2;
    mem_ready = 1'b0;
    rst_n = 1'b1;
    step("fetch_wait", 4'd0, ctl(0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0));

    // lw, no waits: 0,1,2,3,4,0
    op = 6'b100011; mem_ready = 1'b1;
    step("lw.fetch",   4'd0, ctl(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0));
    step("lw.decode",  4'd1, ctl(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0));
    step("lw.memadr",  4'd2, ctl(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0));
    step("lw.memread", 4'd3, ctl(1,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0));
    step("lw.memwb",   4'd4, ctl(0,0,0,0,1,1,0,2'b00,3'b010,2'b00,0,0));

    // sw with two wait cycles in MEMWRITE: 0,1,2,5,5,5,0
    op = 6'b101011;
    step("sw.fetch",  4'd0, ctl(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0));
    step("sw.decode", 4'd1, ctl(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0));
    mem_ready = 1'b0;
    step("sw.memadr", 4'd2, ctl(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0));
    step("sw.mw0",    4'd5, ctl(1,1,0,0,0,0,0,2'b00,3'b010,2'b00,0,0));
    step("sw.mw1",    4'd5, ctl(1,1,0,0,0,0,0,2'b00,3'b010,2'b00,0,0));
    mem_ready = 1'b1;
    step("sw.mw2",    4'd5, ctl(1,1,0,0,0,0,0,2'b00,3'b010,2'b00,0,0));
    check("sw.done", {12'd0, state}, 16'd0);

    // Reset asserted mid-MEMWRITE takes effect without a clock edge
    step("swr.fetch",  4'd0, ctl(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0));
    step("swr.decode", 4'd1, ctl(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0));
    mem_ready = 1'b0;
    step("swr.memadr", 4'd2, ctl(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0));
    check("swr.in_mw", {12'd0, state}, 16'd5);
    rst_n = 1'b0;
    #1;
    check("rstmid.state", {12'd0, state}, 16'd0);
    check("rstmid.memwrite", {15'd0, MemWrite}, 16'd0);
    check("rstmid.ctl", ctl_vec, ctl(0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0));
    #1;
    rst_n = 1'b1; mem_ready = 1'b1;
    step("rstmid.fetch", 4'd0, ctl(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0));

    // R-type, each supported funct: DECODE, EXECUTE, ALUWB, back to FETCH
    op = 6'b000000;
    step("r0.decode", 4'd1, ctl(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0));
    for (int i = 0; i < 5; i++) begin
      funct = fn_tab[i];
      if (i != 0) begin
        step($sformatf("r%0d.fetch", i), 4'd0, ctl(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0));
        step($sformatf("r%0d.decode", i), 4'd1, ctl(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0));
      end
      step($sformatf("r%0d.exec", i), 4'd6, ctl(0,0,0,0,0,0,1,2'b00,ac_tab[i],2'b00,0,0));
      step($sformatf("r%0d.aluwb", i), 4'd7, ctl(0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0,0));
    end

    // R-type with unsupported funct: illegal in EXECUTE, no writeback
    funct = 6'b000000;
    step("rbad.fetch",  4'd0, ctl(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0));
    step("rbad.decode", 4'd1, ctl(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0));
    step("rbad.exec",   4'd6, ctl(0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,1));

    // beq not taken, then taken
    op = 6'b000100; zero = 1'b0;
    step("beq0.fetch",  4'd0, ctl(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0));
    step("beq0.decode", 4'd1, ctl(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0));
    step("beq0.branch", 4'd8, ctl(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,0));
    step("beq1.fetch",  4'd0, ctl(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0));
    step("beq1.decode", 4'd1, ctl(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0));
    zero = 1'b1;
    step("beq1.branch", 4'd8, ctl(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0));
    zero = 1'b0;

    // addi
    op = 6'b001000;
    step("addi.fetch",  4'd0, ctl(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0));
    step("addi.decode", 4'd1, ctl(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0));
    step("addi.exec",   4'd9, ctl(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0));
    step("addi.wb",     4'd10, ctl(0,0,0,0,0,1,0,2'b00,3'b010,2'b00,0,0));

    // j
    op = 6'b000010;
    step("j.fetch",  4'd0, ctl(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0));
    step("j.decode", 4'd1, ctl(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0));
    step("j.jump",   4'd11, ctl(0,0,0,0,0,0,0,2'b00,3'b010,2'b10,1,0));

    // Unsupported op: illegal for the DECODE cycle only, then FETCH
    op = 6'b111111;
    step("bad.fetch",  4'd0, ctl(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0));
    step("bad.decode", 4'd1, ctl(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,1));
    mem_ready = 1'b0;
    step("bad.after",  4'd0, ctl(0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multicycle MIPS datapath: a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback, reusing one ALU and one unified instruction/data memory. It sits beside the datapath, reads opcode/funct from the instruction register and `zero` from the ALU, and drives every mux select and write enable. Memory accesses use a `mem_ready` wait handshake, so the same sequencer works with single-cycle and multi-cycle memories.

## Interface
- No parameters; opcode/funct widths fixed at 6 bits, state encoding fixed at 4 bits.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 6: IR[31:26]; stable from DECODE until the next FETCH.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `IorD` out 1: memory address select (0 = PC, 1 = ALUOut).
- `MemWrite` out 1: memory write enable.
- `IRWrite` out 1: instruction register load.
- `RegDst` out 1: destination register select (0 = rt, 1 = rd).
- `MemtoReg` out 1: writeback source (0 = ALUOut, 1 = Data).
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 1: ALU A source (0 = PC, 1 = A).
- `ALUSrcB` out 2: ALU B source (00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2).
- `ALUControl` out 3: ALU operation (010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt).
- `PCSrc` out 2: next-PC source (00 = ALUResult, 01 = ALUOut, 10 = jump target).
- `PCEn` out 1: PC load enable.
- `illegal` out 1: unsupported op or funct detected.
- `state` out 4: current state, for debug and the testbench.

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Codes 12–15 are unreachable and go to FETCH on the next edge.
- Default for every output is 0, except `ALUControl`, which defaults to 010. Each state asserts only the signals listed below.
- FETCH: ALUSrcB=01, add, PCSrc=00, IorD=0; IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0, then goes to DECODE.
- DECODE: ALUSrcB=11, add (branch target into ALUOut). Next state by op:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → EXECUTE
  - 000100 (beq) → BRANCH
  - 001000 (addi) → ADDIEXEC
  - 000010 (j) → JUMP
  - any other op → FETCH, with `illegal`=1 for that cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: IorD=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1, RegDst=0. Goes to FETCH.
- MEMWRITE: IorD=1, MemWrite=1 for every cycle in the state. Holds until mem_ready, then goes to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00. ALUControl by funct:
  - 100000 → 010
  - 100010 → 110
  - 100100 → 000
  - 100101 → 001
  - 101010 → 111
  - any other funct: ALUControl=010, `illegal`=1, next state FETCH (no writeback); otherwise next state ALUWB.
- ALUWB: RegDst=1, RegWrite=1. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1. Goes to FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, add. Goes to ADDIWB.
- ADDIWB: RegDst=0, RegWrite=1. Goes to FETCH.
- JUMP: PCSrc=10, PCWrite=1. Goes to FETCH.
- PCEn = PCWrite | (Branch & zero).

## Timing
- The state register is the only storage. It is cleared to FETCH asynchronously while rst_n=0 and updates on the rising edge of clk.
- All outputs are combinational functions of state, op, funct, zero and mem_ready; there are no registered outputs.
- While rst_n=0, IRWrite, PCEn, MemWrite and RegWrite are forced to 0, `illegal`=0, and `state`=0. All other outputs take their FETCH values.
- Reset asserted mid-instruction aborts it immediately. No write enable is asserted after rst_n falls.
- Cycles per instruction with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each wait cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- mem_ready is sampled only in FETCH, MEMREAD and MEMWRITE and ignored in all other states.
- `zero` is relevant only in BRANCH, where it must settle within the same cycle.

## Test plan
- Reset: rst_n=0 mid-MEMWRITE → state=0 and MemWrite=0 immediately (asynchronous); after release, FETCH with IRWrite=PCEn=mem_ready.
- lw (op=100011) with mem_ready=1 → states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
- sw with mem_ready low for 2 cycles in MEMWRITE → states 0,1,2,5,5,5,0; MemWrite=1 for all 3 cycles in state 5.
- R-type funct=100010 → ALUControl=110 in EXECUTE; then ALUWB with RegDst=1, RegWrite=1. Repeat for funct 100000, 100100, 100101, 101010.
- beq with zero=0 → PCEn=0 in BRANCH. beq with zero=1 → PCEn=1, PCSrc=01, ALUControl=110.
- Illegal inputs:
  - op=111111 → DECODE→FETCH with illegal=1 for one cycle.
  - R-type funct=000000 → EXECUTE→FETCH with illegal=1 and no RegWrite.
  - j → JUMP with PCEn=1, PCSrc=10.
